mux_key_rr_reg: RTL

//   Registered N-channel keyed selector with valid/ready handshakes. Forwards one

---
 rtl/mux_key_rr_reg.sv | 102 ++++++++++
 1 files changed

// File: rtl/mux_key_rr_reg.sv
// Keyed / round-robin N:1 selector into a single-entry output register; 1-cycle input-to-output latency.
// Backpressure: in_ready is held low while the output register is full and not draining.
module mux_key_rr_reg #(
  parameter int NR_CH    = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [KEY_LEN-1:0]        key,
  input  logic [NR_CH-1:0]          in_valid,
  input  logic [NR_CH*DATA_LEN-1:0] in_data,
  output logic [NR_CH-1:0]          in_ready,
  output logic                      out_valid,
  output logic [DATA_LEN-1:0]       out_data,
  output logic [KEY_LEN-1:0]        out_ch,
  input  logic                      out_ready
);
  localparam int PAD_W = 2 ** KEY_LEN;

  logic                out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0] out_data_q, out_data_d;
  logic [KEY_LEN-1:0]  out_ch_q, out_ch_d;
  logic [KEY_LEN-1:0]  last_grant_q, last_grant_d;

  logic                load;
  logic                cand_vld;
  logic                xfer;
  logic [KEY_LEN-1:0]  grant;
  logic [KEY_LEN-1:0]  scan_ch;
  logic [PAD_W-1:0]    vld_pad;
  logic [PAD_W-1:0]    rdy_pad;
  logic [DATA_LEN-1:0] sel_data;
  int                  scan_idx;

  always_comb begin
    // Nothing is accepted in the reset cycle.
    load     = !rst && (!out_valid_q || out_ready);
    vld_pad  = PAD_W'(in_valid);
    cand_vld = 1'b0;
    grant    = '0;
    scan_ch  = '0;
    scan_idx = 0;
    if (!mode) begin
      cand_vld = int'(key) < NR_CH;
      grant    = key;
    end else begin
      for (int i = 1; i <= NR_CH; i++) begin
        scan_idx = int'(last_grant_q) + i;
        if (scan_idx >= NR_CH) scan_idx = scan_idx - NR_CH;
        scan_ch = KEY_LEN'(scan_idx);
        if (!cand_vld && vld_pad[scan_ch]) begin
          cand_vld = 1'b1;
          grant    = scan_ch;
        end
      end
    end

    rdy_pad = '0;
    if (load && cand_vld) rdy_pad[grant] = 1'b1;
    in_ready = rdy_pad[NR_CH-1:0];
    xfer     = load && cand_vld && vld_pad[grant];

    sel_data = '0;
    for (int n = 0; n < NR_CH; n++) begin
      if (grant == KEY_LEN'(n)) sel_data = in_data[n*DATA_LEN +: DATA_LEN];
    end

    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_ch_d    = grant;
      // Keyed grants must not disturb the round-robin order.
      if (mode) last_grant_d = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      last_grant_q <= KEY_LEN'(NR_CH - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
endmodule
